// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit is the master: it raises req with a stable addr until ack,
// and the memory returns the instruction on data in the ack cycle.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over the imem req/ack bus and
// fills the IF/ID buffer. Handles redirect, flush and stall, including a
// redirect that lands while a request is still outstanding (DRAIN).
// Optional feature macro: FETCH_PERF_EN adds fetch/kill event counters.
//
// state | meaning
// IDLE  | not fetching, waiting for start_i
// FETCH | request at pc outstanding
// HOLD  | instruction captured during stall, waiting for release
// DRAIN | stale request still outstanding after redirect; its data is dropped
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                pc_mux_op_i,
  input  logic [ADDR_W-1:0]   branch_target_i,
  inst_fetch_unit_if.master   imem,
  output logic [ADDR_W-1:0]   if_id_pc_o,
  output logic [31:0]         if_id_inst_o,
  output logic                if_id_valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         fetch_cnt_o,
  output logic [15:0]         kill_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [31:0]       hold_q, hold_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_inst_q, if_id_inst_d;
  logic              if_id_valid_q, if_id_valid_d;

  logic              req_c;
  logic [ADDR_W-1:0] addr_c;
  logic              accept_c;
  logic              kill_c;
  logic [ADDR_W-1:0] target_c;

  // Word-align the redirect target.
  assign target_c = branch_target_i & ~ADDR_W'(3);

  // State and datapath registers; reset may hit mid-request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      drain_addr_q  <= RESET_PC;
      hold_q        <= '0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      hold_q        <= hold_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Next-state, bus outputs and IF/ID update; redirect takes priority over everything.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    hold_d        = hold_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    req_c         = 1'b0;
    addr_c        = pc_q;
    accept_c      = 1'b0;
    kill_c        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pc_mux_op_i) pc_d = target_c;
        if (start_i)     state_d = S_FETCH;
      end

      S_FETCH: begin
        req_c = 1'b1;
        if (pc_mux_op_i) begin
          pc_d = target_c;
          if (imem.ack) begin
            kill_c = 1'b1;
          end else begin
            // The old request must complete at its original address.
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
          if (!stall_i) if_id_valid_d = 1'b0;
        end else if (imem.ack && !stall_i) begin
          accept_c     = 1'b1;
          if_id_pc_d   = pc_q;
          if_id_inst_d = imem.data;
          pc_d         = pc_q + ADDR_W'(4);
        end else if (imem.ack) begin
          hold_d  = imem.data;
          state_d = S_HOLD;
        end else if (!stall_i) begin
          if_id_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (pc_mux_op_i) begin
          pc_d    = target_c;
          kill_c  = 1'b1;
          state_d = S_FETCH;
          if (!stall_i) if_id_valid_d = 1'b0;
        end else if (!stall_i) begin
          accept_c     = 1'b1;
          if_id_pc_d   = pc_q;
          if_id_inst_d = hold_q;
          pc_d         = pc_q + ADDR_W'(4);
          state_d      = S_FETCH;
        end
      end

      S_DRAIN: begin
        req_c  = 1'b1;
        addr_c = drain_addr_q;
        if (pc_mux_op_i) pc_d = target_c;
        if (imem.ack) begin
          kill_c  = 1'b1;
          state_d = S_FETCH;
        end
        if (!stall_i) if_id_valid_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    if (accept_c) if_id_valid_d = 1'b1;

    // Flush wins over stall and over any write; an accepted word becomes a kill.
    if (flush_i) begin
      if_id_valid_d = 1'b0;
      if (accept_c) begin
        accept_c = 1'b0;
        kill_c   = 1'b1;
      end
    end
  end

  assign imem.req      = req_c;
  assign imem.addr     = addr_c;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_inst_o  = if_id_inst_q;
  assign if_id_valid_o = if_id_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] kill_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (accept_c && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (kill_c && (kill_cnt_q != '1))    kill_cnt_q  <= kill_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign kill_cnt_o  = kill_cnt_q;
`endif

endmodule
